// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding icache request, IF/ID register,
// one-entry hold buffer for a response that lands while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_gnt,
  input  logic        icache_rvalid,
  input  logic [31:0] icache_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_kill;
  logic        r_hold_valid;
  logic [31:0] r_hold_instr;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] w_next_pc;

  assign w_next_pc         = r_req_pc + 32'd4;
  assign icache_req        = (r_state == S_ISSUE) && !reset;
  assign icache_addr       = r_pc;
  assign if_id_valid       = r_valid;
  assign if_id_instruction = r_instr;
  assign if_id_pc          = r_if_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ISSUE;
      r_pc         <= RESET_PC & ~32'd3;
      r_req_pc     <= RESET_PC;
      r_kill       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_if_pc      <= RESET_PC;
    end else if (redirect_valid) begin
      // Squash everything younger than the redirect, even under stall.
      r_pc         <= redirect_pc & ~32'd3;
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_hold_valid <= 1'b0;
      case (r_state)
        S_ISSUE: begin
          if (icache_gnt) begin
            r_state <= S_WAIT;
            r_kill  <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
            r_kill  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (icache_rvalid) begin
            r_state <= S_ISSUE;
            r_kill  <= 1'b0;
          end else begin
            r_kill  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_ISSUE;
          r_kill  <= 1'b0;
        end
      endcase
    end else begin
      if (!stall) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
      case (r_state)
        S_ISSUE: begin
          if (icache_gnt) begin
            r_req_pc <= r_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (icache_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_ISSUE;
            end else begin
              r_pc <= w_next_pc;
              // An empty slot can be filled even while decode is stalled.
              if (!stall || !r_valid) begin
                r_valid <= 1'b1;
                r_instr <= icache_rdata;
                r_if_pc <= r_req_pc;
                r_state <= S_ISSUE;
              end else begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= icache_rdata;
                r_state      <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_valid      <= r_hold_valid;
            r_instr      <= r_hold_valid ? r_hold_instr : NOP_INSTR;
            r_if_pc      <= r_req_pc;
            r_hold_valid <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: icache responder model, fetch-address model and an
// IF/ID scoreboard, driven through directed boot/stall/redirect/reset phases.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_gnt;
  logic        icache_rvalid;
  logic [31:0] icache_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk              (clk),
    .reset            (reset),
    .icache_req       (icache_req),
    .icache_addr      (icache_addr),
    .icache_gnt       (icache_gnt),
    .icache_rvalid    (icache_rvalid),
    .icache_rdata     (icache_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stall            (stall),
    .if_id_valid      (if_id_valid),
    .if_id_instruction(if_id_instruction),
    .if_id_pc         (if_id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          n_consumed = 0;
  logic        pend       = 1'b0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = 32'd0;
  logic        kill_b     = 1'b0;
  logic [31:0] exp_addr   = RESET_PC;
  int          lat        = 1;
  logic        gnt_en     = 1'b1;
  logic        force_rv   = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive icache inputs, check outputs, update models,
  // then pass the rising edge and return after the next falling edge.
  task automatic tick();
    logic        resp;
    logic        hs;
    logic        acc;
    logic [31:0] r_addr;
    #1;
    resp   = 1'b0;
    r_addr = pend_addr;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) resp = 1'b1;
    end
    icache_rvalid = resp || force_rv;
    icache_rdata  = resp ? data_of(pend_addr) : 32'hDEAD_BEEF;
    icache_gnt    = gnt_en;
    #1;
    if (!if_id_valid) chk("bubble_nop", if_id_instruction, NOP_INSTR);
    if (icache_req) chk("addr_align", 32'(icache_addr[1:0]), 32'd0);
    if (reset) chk("req_in_reset", 32'(icache_req), 32'd0);
    if (if_id_valid) begin
      chk("ifid_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("ifid_pc", if_id_pc, sb[0].pc);
        chk("ifid_instr", if_id_instruction, sb[0].instr);
        if (!stall && !redirect_valid && !reset) begin
          void'(sb.pop_front());
          n_consumed++;
        end
      end
    end
    hs = icache_req && icache_gnt;
    if (hs) chk("fetch_addr", icache_addr, exp_addr);
    acc = resp && !kill_b && !redirect_valid && !reset;
    if (acc) sb.push_back({r_addr, data_of(r_addr)});
    if (resp) begin
      pend   = 1'b0;
      kill_b = 1'b0;
    end
    if (hs) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = exp_addr;
      kill_b    = 1'b0;
    end
    if (reset) begin
      exp_addr = RESET_PC;
      pend     = 1'b0;
      kill_b   = 1'b0;
      sb.delete();
    end else if (redirect_valid) begin
      exp_addr = redirect_pc & ~32'd3;
      sb.delete();
      if (pend) kill_b = 1'b1;
    end else if (acc) begin
      exp_addr = r_addr + 32'd4;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    icache_gnt = 1'b0; icache_rvalid = 1'b0; icache_rdata = 32'd0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instruction, NOP_INSTR);
    chk("rst_pc", if_id_pc, RESET_PC);
    reset = 1'b0;
    #1;
    chk("first_req", 32'(icache_req), 32'd1);
    chk("first_addr", icache_addr, RESET_PC);

    // boot: back-to-back fetches 0x0, 0x4, 0x8
    repeat (6) tick();
    chk("boot_consumed", 32'(n_consumed), 32'd2);

    // decode stall: second response parks in the hold buffer
    stall = 1'b1;
    repeat (6) tick();
    chk("hold_req", 32'(icache_req), 32'd0);
    chk("hold_ifid_pc", if_id_pc, 32'h8);
    stall = 1'b0;
    tick();
    chk("release_pc", if_id_pc, 32'hC);
    chk("release_req", 32'(icache_req), 32'd1);
    chk("release_addr", icache_addr, 32'h10);

    // redirect while waiting for a response
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (pend && pend_cnt >= 2) break;
      tick();
    end
    chk("reach_wait", 32'(pend && pend_cnt >= 2), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", 32'(if_id_valid), 32'd0);
    for (int i = 0; i < 20 && !icache_req; i++) tick();
    chk("redir_addr", icache_addr, 32'h100);

    // redirect in the same cycle as a grant
    lat = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !icache_req; i++) tick();
    chk("gnt_redir_addr", icache_addr, 32'h200);

    // redirect in ISSUE without grant, then a stray rvalid outside WAIT
    gnt_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("nognt_addr", icache_addr, 32'h300);
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    chk("stale_valid", 32'(if_id_valid), 32'd0);
    chk("stale_addr", icache_addr, 32'h300);

    // wrap-around fetch at the top of the address space
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    repeat (2) tick();
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", icache_addr, 32'h0);
    repeat (3) tick();

    // reset while an instruction sits in the hold buffer
    stall = 1'b1;
    repeat (6) tick();
    chk("hold2_req", 32'(icache_req), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst2_valid", 32'(if_id_valid), 32'd0);
    chk("rst2_instr", if_id_instruction, NOP_INSTR);
    chk("rst2_pc", if_id_pc, RESET_PC);
    chk("rst2_req", 32'(icache_req), 32'd0);
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("rst2_addr", icache_addr, RESET_PC);
    repeat (8) tick();

    // steady-state rate: one instruction every two cycles
    c0 = n_consumed;
    repeat (20) tick();
    chk("throughput", 32'(n_consumed - c0), 32'd10);

    gnt_en = 1'b0;
    repeat (6) tick();
    chk("drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
